tt_sweep_checker: RTL and testbench

Synthesizable exhaustive truth-table sweeper and checker for an N-input, single-output combinational function. It drives every input vector 0..2^N−1 in ascending order, holding each vector for a programmable number of clock cycles. On the last cycle of each hold it samples the DUT output and compares it against a parameterised expected truth table. Errors are counted and the first failing vector is recorded. It replaces hand-written vector lists in our combinational-exercise benches and can also run on hardware for on-board self-test.

---
 rtl/tt_sweep_checker_pkg.sv | 20 ++
 rtl/tt_sweep_checker_sat_counter.sv | 35 +++
 rtl/tt_sweep_checker.sv | 131 +++++++++++++
 tb/tb_tt_sweep_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and
// ready-made expected tables for common 3-input functions.
package tt_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] EXPECT_MAJ3 = 8'hE8;
    localparam logic [7:0] EXPECT_PAR3 = 8'h96;
    localparam logic [7:0] EXPECT_AND3 = 8'h80;

    // Width of a counter running 0..d-1, never less than one bit.
    function automatic int dwell_w(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/tt_sweep_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input vector in order, holds
// each for DWELL cycles, and checks the DUT output on the last cycle of each hold.
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int                  N      = 3,
    parameter int                  DWELL  = 4,
    parameter logic [(1<<N)-1:0]   EXPECT = EXPECT_MAJ3,
    parameter int                  CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic          dut_f,
    output logic [N-1:0]  vec,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] sweep_cnt,
    output logic          ff_valid,
    output logic [N-1:0]  ff_vec
);

    localparam int            DW         = dwell_w(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  VEC_LAST   = '1;

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          ff_valid_q, ff_valid_d;
    logic [N-1:0]  ff_vec_q, ff_vec_d;
    logic          cnt_clr;
    logic          err_inc;
    logic          sweep_inc;
    logic          mismatch;

    assign mismatch = (dut_f != EXPECT[vec_q]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        dwell_d    = dwell_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        cnt_clr    = 1'b0;
        err_inc    = 1'b0;
        sweep_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start outranks a coincident abort outside of a sweep
                if (start) begin
                    state_d    = ST_SWEEP;
                    vec_d      = '0;
                    dwell_d    = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SWEEP: begin
                // abort suppresses any sample or wrap bookkeeping on this edge
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    vec_d   = vec_q + 1'b1;
                    if (mismatch) begin
                        err_inc = 1'b1;
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_vec_d   = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        sweep_inc = 1'b1;
                        if (!loop) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            dwell_q    <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            dwell_q    <= dwell_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    sat_counter #(.W(CW)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    sat_counter #(.W(CW)) u_sweep_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (sweep_inc),
        .cnt_o (sweep_cnt)
    );

    assign vec      = vec_q;
    assign busy     = (state_q == ST_SWEEP);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (err_cnt == '0);
    assign ff_valid = ff_valid_q;
    assign ff_vec   = ff_vec_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a 3-input majority sweep with a settling DUT
// model and a 2-input XOR sweep exercising loop mode.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instance A: defaults (N=3, DWELL=4, majority)
    logic        start_a = 1'b0, abort_a = 1'b0, loop_a = 1'b0;
    logic        dut_f_a;
    logic [2:0]  vec_a, ffvec_a;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic [15:0] err_a, swp_a;

    // instance B: N=2, DWELL=2, XOR
    logic        start_b = 1'b0, abort_b = 1'b0, loop_b = 1'b0;
    logic        dut_f_b;
    logic [1:0]  vec_b, ffvec_b;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [15:0] err_b, swp_b;

    tt_sweep_checker u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .loop(loop_a),
        .dut_f(dut_f_a), .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .sweep_cnt(swp_a), .ff_valid(ffv_a), .ff_vec(ffvec_a)
    );

    tt_sweep_checker #(.N(2), .DWELL(2), .EXPECT(4'b0110), .CW(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .loop(loop_b),
        .dut_f(dut_f_b), .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .sweep_cnt(swp_b), .ff_valid(ffv_b), .ff_vec(ffvec_b)
    );

    // Majority DUT model: output is garbage until the vector has been stable
    // for three cycles, then the (optionally flipped) majority value.
    logic [7:0] flip_a = 8'h00;
    logic       tie0_a = 1'b0;
    logic [2:0] last_vec_a = 3'd0;
    int         age_a = 0;
    logic       garb_a = 1'b0;
    logic       good_a;

    always @(negedge clk) begin
        if (vec_a != last_vec_a) age_a <= 0;
        else if (age_a < 1000) age_a <= age_a + 1;
        last_vec_a <= vec_a;
        garb_a     <= 1'($urandom);
    end

    assign good_a  = ($countones(vec_a) >= 2) ^ flip_a[vec_a];
    assign dut_f_a = tie0_a ? 1'b0 : ((age_a >= 3) ? good_a : garb_a);

    logic [3:0] flip_b = 4'h0;
    assign dut_f_b = (vec_b[0] ^ vec_b[1]) ^ flip_b[vec_b];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: mismatches of the model against majority over vectors 0..upto-1.
    function automatic void model_a(input logic [7:0] flip, input bit tie0, input int upto,
                                    output int errs, output bit ffv, output logic [2:0] ffvec);
        bit expb, got;
        errs = 0; ffv = 0; ffvec = 3'd0;
        for (int v = 0; v < upto; v++) begin
            expb = ($countones(3'(v)) >= 2);
            got  = tie0 ? 1'b0 : (expb ^ flip[v]);
            if (got != expb) begin
                errs++;
                if (!ffv) begin ffv = 1; ffvec = 3'(v); end
            end
        end
    endfunction

    task automatic wait_vec_a(input logic [2:0] v, input string tag);
        int n = 0;
        while (vec_a !== v && n < 100) begin tick(); n++; end
        chk_eq(tag, 32'(vec_a === v), 32'd1);
    endtask

    task automatic run_a(input logic [7:0] flip, input bit tie0);
        int errs; bit ffv; logic [2:0] ffvec;
        flip_a = flip; tie0_a = tie0;
        model_a(flip, tie0, 8, errs, ffv, ffvec);
        @(negedge clk); start_a = 1'b1;
        tick(); start_a = 1'b0;
        chk_eq("a_busy_start", 32'(busy_a), 32'd1);
        chk_eq("a_vec_start",  32'(vec_a),  32'd0);
        chk_eq("a_err_clear",  32'(err_a),  32'd0);
        chk_eq("a_done_clear", 32'(done_a), 32'd0);
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c < 32) chk_eq("a_vec_step", 32'(vec_a), 32'(c / 4));
            if (c == 31) chk_eq("a_done_early", 32'(done_a), 32'd0);
        end
        chk_eq("a_done",   32'(done_a),  32'd1);
        chk_eq("a_busy",   32'(busy_a),  32'd0);
        chk_eq("a_pass",   32'(pass_a),  32'(errs == 0));
        chk_eq("a_err",    32'(err_a),   32'(errs));
        chk_eq("a_ffv",    32'(ffv_a),   32'(ffv));
        chk_eq("a_ffvec",  32'(ffvec_a), 32'(ffvec));
        chk_eq("a_sweeps", 32'(swp_a),   32'd1);
        $display("run_a flip=%02h tie0=%0d expected_errs=%0d err_cnt=%0d", flip, tie0, errs, err_a);
    endtask

    task automatic run_b(input logic [3:0] flip);
        int per; bit ffv; logic [1:0] ffvec;
        bit expb;
        per = 0; ffv = 0; ffvec = 2'd0;
        for (int v = 0; v < 4; v++) begin
            expb = v[0] ^ v[1];
            if ((expb ^ flip[v]) != expb) begin
                per++;
                if (!ffv) begin ffv = 1; ffvec = 2'(v); end
            end
        end
        flip_b = flip;
        @(negedge clk); loop_b = 1'b1; start_b = 1'b1;
        tick(); start_b = 1'b0;
        chk_eq("b_vec_start", 32'(vec_b), 32'd0);
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 24) loop_b = 1'b0;
            if (c < 32) chk_eq("b_vec_step", 32'(vec_b), 32'((c / 2) % 4));
            if (c < 32) chk_eq("b_busy_loop", 32'(busy_b), 32'd1);
            if (c == 8)  chk_eq("b_sweeps_1", 32'(swp_b), 32'd1);
            if (c == 16) chk_eq("b_err_2sw",  32'(err_b), 32'(2 * per));
        end
        chk_eq("b_done",   32'(done_b),  32'd1);
        chk_eq("b_sweeps", 32'(swp_b),   32'd4);
        chk_eq("b_err",    32'(err_b),   32'(4 * per));
        chk_eq("b_pass",   32'(pass_b),  32'(per == 0));
        chk_eq("b_ffv",    32'(ffv_b),   32'(ffv));
        chk_eq("b_ffvec",  32'(ffvec_b), 32'(ffvec));
        $display("run_b flip=%01h per_sweep_errs=%0d err_cnt=%0d sweeps=%0d", flip, per, err_b, swp_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int errs; bit ffv; logic [2:0] ffvec;

        tick();
        chk_eq("rst_busy",  32'(busy_a),  32'd0);
        chk_eq("rst_done",  32'(done_a),  32'd0);
        chk_eq("rst_vec",   32'(vec_a),   32'd0);
        chk_eq("rst_err",   32'(err_a),   32'd0);
        chk_eq("rst_ffv",   32'(ffv_a),   32'd0);
        chk_eq("rst_b_swp", 32'(swp_b),   32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) tick();
        chk_eq("idle_busy", 32'(busy_a), 32'd0);

        run_a(8'h00, 1'b0);
        run_a(8'h20, 1'b0);
        run_a(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) run_a(8'($urandom_range(0, 255)), 1'b0);

        // abort with retained counters; start during SWEEP is ignored
        flip_a = 8'h03; tie0_a = 1'b0;
        model_a(8'h03, 1'b0, 4, errs, ffv, ffvec);
        @(negedge clk); start_a = 1'b1;
        tick(); start_a = 1'b0;
        wait_vec_a(3'd2, "wait_vec2");
        @(negedge clk); start_a = 1'b1;
        tick(); start_a = 1'b0;
        chk_eq("ign_start_vec", 32'(vec_a), 32'd2);
        chk_eq("ign_start_err", 32'(err_a), 32'd2);
        wait_vec_a(3'd4, "wait_vec4");
        tick();
        @(negedge clk); abort_a = 1'b1;
        tick(); abort_a = 1'b0;
        chk_eq("abort_busy",  32'(busy_a),  32'd0);
        chk_eq("abort_done",  32'(done_a),  32'd0);
        chk_eq("abort_pass",  32'(pass_a),  32'd0);
        chk_eq("abort_err",   32'(err_a),   32'(errs));
        chk_eq("abort_ffv",   32'(ffv_a),   32'(ffv));
        chk_eq("abort_ffvec", 32'(ffvec_a), 32'(ffvec));
        chk_eq("abort_swp",   32'(swp_a),   32'd0);
        repeat (10) tick();
        chk_eq("abort_idle", 32'(busy_a), 32'd0);
        chk_eq("abort_hold", 32'(vec_a),  32'd4);
        $display("abort at vec=4 err_cnt=%0d ff_vec=%0d", err_a, ffvec_a);

        // start and abort together outside a sweep: start wins
        @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
        tick(); start_a = 1'b0; abort_a = 1'b0;
        chk_eq("restart_busy", 32'(busy_a), 32'd1);
        chk_eq("restart_vec",  32'(vec_a),  32'd0);
        chk_eq("restart_err",  32'(err_a),  32'd0);
        chk_eq("restart_ffv",  32'(ffv_a),  32'd0);

        // asynchronous reset between edges at vec=6
        wait_vec_a(3'd6, "wait_vec6");
        chk_eq("pre_rst_err", 32'(err_a), 32'd2);
        @(posedge clk); #3; rst = 1'b1;
        #1;
        chk_eq("arst_vec",   32'(vec_a),   32'd0);
        chk_eq("arst_busy",  32'(busy_a),  32'd0);
        chk_eq("arst_done",  32'(done_a),  32'd0);
        chk_eq("arst_pass",  32'(pass_a),  32'd0);
        chk_eq("arst_err",   32'(err_a),   32'd0);
        chk_eq("arst_swp",   32'(swp_a),   32'd0);
        chk_eq("arst_ffv",   32'(ffv_a),   32'd0);
        chk_eq("arst_ffvec", 32'(ffvec_a), 32'd0);
        #2; rst = 1'b0;
        repeat (6) tick();
        chk_eq("post_rst_idle", 32'(busy_a), 32'd0);
        chk_eq("post_rst_vec",  32'(vec_a),  32'd0);
        $display("async reset at vec=6 cleared all outputs");
        run_a(8'($urandom_range(0, 255)), 1'b0);

        run_b(4'h0);
        run_b(4'($urandom_range(1, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
